led_matrix_scan: RTL and testbench
==================================

# led_matrix_scan

Scans the board's 4x4 LED matrix from a double-buffered 16-pixel frame store and sets per-pixel brightness with 4-bit PWM. It sits directly upstream of the kled/aled pin stage: it produces the anode levels and the cathode SB_IO output-enables that the top level wires to the package pins. Pattern logic writes pixels into the back buffer and requests a swap, which the block applies only at a frame boundary, so a frame never tears.

## Interface
- ROW_CYCLES, 187: clocks per PWM step, range 1..65535. Default gives about 4 kHz frame rate at 48 MHz.
- BLANK_CYCLES, 8: all-off dead time before each row, range 1..255.
- clk  in  1  48 MHz SB_HFOSC clock; the block's only clock.
- resetn  in  1  asynchronous, active-low reset.
- en  in  1  scan enable. Low blanks the outputs and parks the scan.
- wr_en  in  1  write strobe for the back buffer.
- wr_addr  in  4  pixel index = row*4 + col.
- wr_data  in  4  brightness level, 0 = off, 15 = 15/16 duty.
- swap_req  in  1  single-cycle pulse requesting a front/back exchange.
- swap_ack  out  1  single-cycle pulse when the swap takes effect.
- frame_start  out  1  single-cycle pulse at the start of row 0 blanking.
- aled  out  4  anode levels, active high, bit c = column c.
- kled_oe  out  4  one-hot cathode output-enable, bit r = row r. Feeds SB_IO OUTPUT_ENABLE; D_OUT_0 is tied to 1'b0 at the top level.

## Operation
- Storage: two 16x4 buffers, A and B, plus a front-select bit. Reset clears both buffers to 0 and selects A as front.
- Writes: wr_en=1 stores wr_data at wr_addr in the buffer that is back at that clock edge. Writes are accepted every cycle, including while en=0.
- Swap handling:
  - swap_req sets a pending flag.
  - Further requests while pending are absorbed; one swap results.
  - The swap executes on the last clock of row 3's DRIVE. The front-select toggles, the pending flag clears and swap_ack pulses in that cycle.
  - When a write and a swap execute on the same edge, the write lands in the old back buffer, which is the new front.
  - A swap_req arriving in the executing cycle stays pending for the next frame.
- State machine: BLANK and DRIVE, with counters row (2b), step (4b), cyc (16b) and blank count (8b).
  - BLANK lasts BLANK_CYCLES clocks, then goes to DRIVE with step=0 and cyc=0.
  - In DRIVE, cyc counts 0..ROW_CYCLES-1. At wrap, step increments.
  - After step 15 wraps, go to BLANK with row+1. Row 3 wraps to 0.
  - frame_start pulses on the first BLANK clock of row 0.
- Outputs (registered, decoded from the current state):
  - In BLANK: aled=0000 and kled_oe=0000.
  - In DRIVE of row r, step s: kled_oe = 1<<r, and aled[c] = (s < front[r*4+c]), an unsigned 4-bit compare.
- en=0:
  - The next edge forces BLANK with row=0 and zeroes all counters.
  - aled, kled_oe and frame_start stay 0 from then on.
  - A pending swap is held and does not execute.
  - The scan restarts with row 0 BLANK on the first edge with en=1.

## Timing
- Reset values: aled=0, kled_oe=0, swap_ack=0, frame_start=0. State is BLANK, row 0, all counters 0, swap not pending.
- Output latency: one clock after the state change.
- Startup: counting edge 1 as the first edge with resetn=1 and en=1:
  - frame_start is high after edge 1.
  - Outputs are blank for BLANK_CYCLES clocks.
  - kled_oe=0001 holds for 16*ROW_CYCLES clocks.
- Row period = BLANK_CYCLES + 16*ROW_CYCLES clocks. Frame period = 4x the row period.
- Never more than one kled_oe bit is high. Every row change passes through at least BLANK_CYCLES all-zero clocks.
- Level L on a pixel gives exactly L*ROW_CYCLES lit clocks per row period.
- Reset asserted mid-row:
  - Outputs go to 0 asynchronously.
  - Buffer contents are cleared.
  - The pending swap is dropped.

## Test plan
All scenarios use ROW_CYCLES=2 and BLANK_CYCLES=1, giving a 33-clock row and a 132-clock frame.
- Reset release with en=1 and buffers empty:
  - frame_start pulses once per 132 clocks.
  - kled_oe cycles 0001, 0010, 0100, 1000, each for 32 clocks separated by 1 blank clock.
  - aled stays 0000.
- Write pixel 5 (row 1, col 1) = 15, then swap:
  - swap_ack appears only at the end of row 3.
  - In the next frame, aled=0010 during row 1 for 30 of 32 DRIVE clocks, then 0 for the last 2.
- Levels 0, 1, 8 and 15 on row 0, cols 0..3: lit clocks per row are 0, 2, 16 and 30 respectively.
- Three swap_req pulses within one frame: exactly one swap_ack, and the front toggles once. A request on the ack cycle yields another ack one frame later.
- Drop en mid-row 2:
  - Outputs go 0 within 1 clock.
  - A pending swap is not acked.
  - On re-enable, frame_start pulses and row 0 restarts.
- Assert resetn mid-DRIVE:
  - aled and kled_oe go 0 immediately.
  - After release, all pixels read as level 0 (aled stays 0 for a full frame).

Source files
------------

// File: rtl/led_matrix_scan.sv
// 4x4 LED matrix scanner with a double-buffered 16-pixel frame store and 4-bit PWM.
// Swaps are applied only on the last DRIVE clock of row 3, so a frame never tears.
module led_matrix_scan #(
  parameter int unsigned ROW_CYCLES   = 187,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_en,
  input  logic       i_wr_en,
  input  logic [3:0] i_wr_addr,
  input  logic [3:0] i_wr_data,
  input  logic       i_swap_req,
  output logic       o_swap_ack,
  output logic       o_frame_start,
  output logic [3:0] o_aled,
  output logic [3:0] o_kled_oe
);
  localparam logic [15:0] CYC_LAST = 16'(ROW_CYCLES - 1);
  localparam logic [7:0]  BLK_LAST = 8'(BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

  state_t r_state, w_state;
  logic [1:0]  r_row,   w_row;
  logic [3:0]  r_step,  w_step;
  logic [15:0] r_cyc,   w_cyc;
  logic [7:0]  r_blank, w_blank;

  logic             r_front;  // 0: A is front, 1: B is front
  logic             r_pend;
  logic [15:0][3:0] r_buf_a, r_buf_b;
  logic [15:0][3:0] w_front_buf;

  logic       w_row_end, w_swap_exec;
  logic [3:0] w_lit, w_aled, w_kled;
  logic       w_fs;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= ST_BLANK;
      r_row   <= '0;
      r_step  <= '0;
      r_cyc   <= '0;
      r_blank <= '0;
    end else begin
      r_state <= w_state;
      r_row   <= w_row;
      r_step  <= w_step;
      r_cyc   <= w_cyc;
      r_blank <= w_blank;
    end
  end

  always_comb begin
    w_state = r_state;
    w_row   = r_row;
    w_step  = r_step;
    w_cyc   = r_cyc;
    w_blank = r_blank;
    if (!i_en) begin
      w_state = ST_BLANK;
      w_row   = '0;
      w_step  = '0;
      w_cyc   = '0;
      w_blank = '0;
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (r_blank == BLK_LAST) begin
            w_state = ST_DRIVE;
            w_blank = '0;
            w_step  = '0;
            w_cyc   = '0;
          end else begin
            w_blank = r_blank + 8'd1;
          end
        end
        ST_DRIVE: begin
          if (r_cyc == CYC_LAST) begin
            w_cyc = '0;
            if (r_step == 4'hf) begin
              w_state = ST_BLANK;
              w_row   = r_row + 2'd1;
              w_step  = '0;
            end else begin
              w_step = r_step + 4'd1;
            end
          end else begin
            w_cyc = r_cyc + 16'd1;
          end
        end
        default: w_state = ST_BLANK;
      endcase
    end
  end

  assign w_row_end   = (r_state == ST_DRIVE) && (r_cyc == CYC_LAST) && (r_step == 4'hf);
  assign w_swap_exec = i_en && r_pend && w_row_end && (r_row == 2'd3);

  // A write on the swap edge still targets the pre-swap back buffer (the new front).
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_buf_a <= '0;
      r_buf_b <= '0;
      r_front <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      if (i_wr_en) begin
        if (r_front) r_buf_a[i_wr_addr] <= i_wr_data;
        else         r_buf_b[i_wr_addr] <= i_wr_data;
      end
      if (w_swap_exec) r_front <= ~r_front;
      r_pend <= (r_pend & ~w_swap_exec) | i_swap_req;
    end
  end

  assign w_front_buf = r_front ? r_buf_b : r_buf_a;

  for (genvar c = 0; c < 4; c++) begin : g_col
    localparam logic [1:0] COL = 2'(c);
    assign w_lit[c] = r_step < w_front_buf[{r_row, COL}];
  end

  always_comb begin
    w_aled = '0;
    w_kled = '0;
    w_fs   = 1'b0;
    if (i_en) begin
      if (r_state == ST_DRIVE) begin
        w_kled = 4'b0001 << r_row;
        w_aled = w_lit;
      end else begin
        w_fs = (r_row == 2'd0) && (r_blank == 8'd0);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_aled        <= '0;
      o_kled_oe     <= '0;
      o_frame_start <= 1'b0;
      o_swap_ack    <= 1'b0;
    end else begin
      o_aled        <= w_aled;
      o_kled_oe     <= w_kled;
      o_frame_start <= w_fs;
      o_swap_ack    <= w_swap_exec;
    end
  end
endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed + randomized bench for led_matrix_scan; reference model works from the
// scan position within the frame rather than from an explicit state machine.
module tb_led_matrix_scan;
  localparam int RC    = 2;
  localparam int BC    = 1;
  localparam int ROWP  = BC + 16 * RC;
  localparam int FRAME = 4 * ROWP;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b0, wr_en = 1'b0, swap_req = 1'b0;
  logic [3:0] wr_addr = '0, wr_data = '0;
  logic       swap_ack, frame_start;
  logic [3:0] aled, kled_oe;

  int checks = 0, errors = 0;
  int mbuf[2][16];
  int mfront, mp;
  bit mpend;
  int lit[4];
  int nack, nfs;

  led_matrix_scan #(.ROW_CYCLES(RC), .BLANK_CYCLES(BC)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_en(en), .i_wr_en(wr_en),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_swap_req(swap_req),
    .o_swap_ack(swap_ack), .o_frame_start(frame_start),
    .o_aled(aled), .o_kled_oe(kled_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int b = 0; b < 2; b++) for (int i = 0; i < 16; i++) mbuf[b][i] = 0;
    mfront = 0; mpend = 1'b0; mp = 0;
  endtask

  task automatic clr();
    for (int c = 0; c < 4; c++) lit[c] = 0;
    nack = 0; nfs = 0;
  endtask

  // One clock: drive inputs, advance the model, compare every output.
  task automatic step(input logic e, input logic we, input logic [3:0] wa,
                      input logic [3:0] wd, input logic rq);
    int fp, row, off, s;
    logic [3:0] ea, ek;
    logic efs, eack;
    en = e; wr_en = we; wr_addr = wa; wr_data = wd; swap_req = rq;
    @(posedge clk);
    fp = mp % FRAME; row = fp / ROWP; off = fp % ROWP;
    ea = '0; ek = '0; efs = 1'b0;
    if (e) begin
      if (off < BC) efs = (fp == 0);
      else begin
        ek = 4'(1 << row);
        s  = (off - BC) / RC;
        for (int c = 0; c < 4; c++) ea[c] = (s < mbuf[mfront][row*4 + c]);
      end
    end
    eack = e && mpend && (fp == FRAME - 1);
    if (we) mbuf[1 - mfront][wa] = int'(wd);
    if (eack) mfront = 1 - mfront;
    mpend = (mpend && !eack) || rq;
    mp = e ? mp + 1 : 0;
    #1;
    chk("aled", 32'(aled), 32'(ea));
    chk("kled_oe", 32'(kled_oe), 32'(ek));
    chk("frame_start", 32'(frame_start), 32'(efs));
    chk("swap_ack", 32'(swap_ack), 32'(eack));
    chk("kled_onehot", 32'($countones(kled_oe) <= 1), 32'd1);
    for (int c = 0; c < 4; c++) if (aled[c]) lit[c]++;
    if (swap_ack) nack++;
    if (frame_start) nfs++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  initial begin
    logic in_drive;
    mreset(); clr();
    repeat (2) @(negedge clk);
    chk("rst_aled", 32'(aled), 32'd0);
    chk("rst_kled", 32'(kled_oe), 32'd0);
    chk("rst_ack", 32'(swap_ack), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    resetn = 1'b1;

    // Empty buffers: blank scan over two frames
    idle(2 * FRAME);
    chk("empty_fs_count", 32'(nfs), 32'd2);
    chk("empty_lit", 32'(lit[0] + lit[1] + lit[2] + lit[3]), 32'd0);

    // Pixel 5 = 15 then swap
    clr();
    step(1'b1, 1'b1, 4'd5, 4'd15, 1'b1);
    idle(FRAME - 1);
    chk("pix5_ack", 32'(nack), 32'd1);
    clr();
    idle(FRAME);
    chk("pix5_lit", 32'(lit[1]), 32'd30);
    chk("pix5_other", 32'(lit[0] + lit[2] + lit[3]), 32'd0);

    // Levels 0,1,8,15 on row 0
    clr();
    step(1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 4'd1, 4'd1, 1'b0);
    step(1'b1, 1'b1, 4'd2, 4'd8, 1'b0);
    step(1'b1, 1'b1, 4'd3, 4'd15, 1'b1);
    idle(FRAME - 4);
    chk("lvl_ack", 32'(nack), 32'd1);
    clr();
    idle(FRAME);
    chk("lvl0", 32'(lit[0]), 32'd0);
    chk("lvl1", 32'(lit[1]), 32'd2);
    chk("lvl8", 32'(lit[2]), 32'd16);
    chk("lvl15", 32'(lit[3]), 32'd30);

    // Repeated requests collapse; a request in the executing cycle carries over
    clr();
    for (int i = 0; i < FRAME; i++)
      step(1'b1, 1'b0, 4'd0, 4'd0, (i == 0) || (i == 10) || (i == 50) || (i == FRAME - 1));
    chk("multi_req_ack", 32'(nack), 32'd1);
    clr();
    idle(FRAME);
    chk("carry_req_ack", 32'(nack), 32'd1);
    chk("toggled_front_col1", 32'(lit[1]), 32'd30);
    chk("toggled_front_col3", 32'(lit[3]), 32'd0);

    // Drop en mid row 2 with a swap pending
    idle(2 * ROWP + 10);
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    clr();
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("en_off_kled", 32'(kled_oe), 32'd0);
    chk("en_off_aled", 32'(aled), 32'd0);
    for (int i = 0; i < 19; i++) step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("en_off_no_ack", 32'(nack), 32'd0);
    clr();
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("reenable_fs", 32'(frame_start), 32'd1);
    idle(FRAME - 1);
    chk("reenable_fs_count", 32'(nfs), 32'd1);
    chk("held_swap_ack", 32'(nack), 32'd1);

    // Randomized traffic with occasional enable drops
    for (int i = 0; i < 1500; i++) begin
      logic e;
      e = !((i % 400) >= 390) && ($urandom_range(0, 299) != 0);
      step(e, $urandom_range(0, 3) == 0, 4'($urandom), 4'($urandom),
           $urandom_range(0, 59) == 0);
    end

    // Reset asserted mid-DRIVE
    in_drive = 1'b0;
    for (int i = 0; i < 200 && !in_drive; i++) begin
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      in_drive = (kled_oe != 4'd0);
    end
    chk("reach_drive", 32'(in_drive), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_aled", 32'(aled), 32'd0);
    chk("async_rst_kled", 32'(kled_oe), 32'd0);
    mreset();
    @(negedge clk);
    resetn = 1'b1;
    clr();
    idle(FRAME);
    chk("post_rst_lit", 32'(lit[0] + lit[1] + lit[2] + lit[3]), 32'd0);
    chk("post_rst_fs", 32'(nfs), 32'd1);
    chk("post_rst_no_ack", 32'(nack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
